// File: rtl/tmds_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tmds_pll_supervisor
// Lock supervisor and reset sequencer for NUM_PLL TMDS PLLs, clocked by the
// 27 MHz board clock. Pulses PLL reset, qualifies the synchronised LOCK as
// stable, then releases the derived-domain resets in ascending order. Retries
// on lock timeout, recovers from lock loss and applies divider-mode requests.
//
// Ports
//   clkin       in   1        reference clock, sole clock
//   reset       in   1        synchronous, active-high
//   lock        in   NUM_PLL  PLL LOCK outputs, asynchronous to clkin
//   pll_reset   out  NUM_PLL  PLL RESET, all bits identical
//   domain_rst  out  NUM_PLL  active-high reset per derived clock domain
//   mode_valid  in   1        mode change request
//   mode_sel    in   MODE_W   requested divider mode
//   mode_ready  out  1        combinational from state: high in RUN and FAIL
//   cur_mode    out  MODE_W   applied divider mode
//   mode_err    out  1        one-cycle pulse on an accepted out-of-range mode
//   all_locked  out  1        high only in RUN
//   fail        out  1        high only in FAIL
//   retry_cnt   out  4        failed attempts since last success/mode change
// -----------------------------------------------------------------------------
module tmds_pll_supervisor #(
    parameter int unsigned NUM_PLL      = 2,
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned RST_PULSE    = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned STAGGER      = 8,
    parameter int unsigned MAX_RETRY    = 7,
    localparam int unsigned MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic [NUM_PLL-1:0]  lock,
    output logic [NUM_PLL-1:0]  pll_reset,
    output logic [NUM_PLL-1:0]  domain_rst,
    input  logic                mode_valid,
    input  logic [MODE_W-1:0]   mode_sel,
    output logic                mode_ready,
    output logic [MODE_W-1:0]   cur_mode,
    output logic                mode_err,
    output logic                all_locked,
    output logic                fail,
    output logic [3:0]          retry_cnt
);

    // Cycles from RELEASE entry until the last domain reset drops.
    localparam int unsigned REL_SPAN = STAGGER * (NUM_PLL - 1);
    localparam int unsigned MAX_A    = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int unsigned MAX_B    = (REL_SPAN > LOCK_STABLE) ? REL_SPAN : LOCK_STABLE;
    localparam int unsigned CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PLL-1:0]   sync1_q, sync2_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     stab_q, stab_d;
    logic [3:0]           retry_q, retry_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic                 mode_err_q, mode_err_d;
    logic [NUM_PLL-1:0]   pll_reset_q, pll_reset_d;
    logic [NUM_PLL-1:0]   domain_rst_q, domain_rst_d;
    logic                 all_locked_q, all_locked_d;
    logic                 fail_q, fail_d;

    logic                 all_lk_c;
    logic                 accept_c;
    logic                 mode_ok_c;
    logic                 retry_left_c;
    logic [3:0]           retry_inc_c;

    assign all_lk_c     = &sync2_q;
    assign mode_ready   = (state_q == ST_RUN) || (state_q == ST_FAIL);
    assign accept_c     = mode_ready && mode_valid;
    assign retry_inc_c  = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
    assign retry_left_c = (32'(retry_q) + 32'd1) < MAX_RETRY;

    // When MODE_W bits cannot encode an out-of-range value every code is valid.
    if (NUM_MODES >= (2 ** MODE_W)) begin : g_mode_full
        assign mode_ok_c = 1'b1;
    end else begin : g_mode_part
        assign mode_ok_c = (mode_sel < MODE_W'(NUM_MODES));
    end

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stab_d       = stab_q;
        retry_d      = retry_q;
        mode_d       = mode_q;
        mode_err_d   = 1'b0;
        pll_reset_d  = '1;
        domain_rst_d = '1;
        all_locked_d = 1'b0;
        fail_d       = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                // Both counters include the current cycle; stable wins a tie.
                stab_d = all_lk_c ? stab_q + CNT_W'(1) : '0;
                cnt_d  = cnt_q + CNT_W'(1);
                if (stab_d == CNT_W'(LOCK_STABLE)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else if (cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
                    retry_d = retry_inc_c;
                    state_d = retry_left_c ? ST_PLL_RST : ST_FAIL;
                    cnt_d   = '0;
                    stab_d  = '0;
                end
            end

            ST_RELEASE: begin
                if (!all_lk_c) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(REL_SPAN)) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN, ST_FAIL: begin
                if (state_q == ST_RUN && !all_lk_c) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
                // An accepted valid request overrides a simultaneous lock loss.
                if (accept_c) begin
                    if (mode_ok_c) begin
                        mode_d  = mode_sel;
                        retry_d = 4'd0;
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end else begin
                        mode_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
                stab_d  = '0;
            end
        endcase

        // Outputs follow the state being entered so they change with it.
        if (state_d != ST_PLL_RST && state_d != ST_FAIL) begin
            pll_reset_d = '0;
        end
        if (state_d == ST_RUN) begin
            domain_rst_d = '0;
        end else if (state_d == ST_RELEASE) begin
            for (int unsigned i = 0; i < NUM_PLL; i++) begin
                domain_rst_d[i] = (cnt_d < CNT_W'(STAGGER * i));
            end
        end
        all_locked_d = (state_d == ST_RUN);
        fail_d       = (state_d == ST_FAIL);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q      <= ST_PLL_RST;
            sync1_q      <= '0;
            sync2_q      <= '0;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= 4'd0;
            mode_q       <= MODE_W'(DEFAULT_MODE);
            mode_err_q   <= 1'b0;
            pll_reset_q  <= '1;
            domain_rst_q <= '1;
            all_locked_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= lock;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            mode_q       <= mode_d;
            mode_err_q   <= mode_err_d;
            pll_reset_q  <= pll_reset_d;
            domain_rst_q <= domain_rst_d;
            all_locked_q <= all_locked_d;
            fail_q       <= fail_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign domain_rst = domain_rst_q;
    assign cur_mode   = mode_q;
    assign mode_err   = mode_err_q;
    assign all_locked = all_locked_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_tmds_pll_supervisor
// Directed bench for tmds_pll_supervisor with a cycle-level behavioural model.
// The PLL stand-in holds LOCK low while its RESET is high, otherwise follows
// lock_req. NUM_MODES is 5 so the 3-bit mode port can carry an illegal code.
// -----------------------------------------------------------------------------
module tb_tmds_pll_supervisor;

    localparam int NUM_PLL      = 2;
    localparam int NUM_MODES    = 5;
    localparam int MODE_W       = 3;
    localparam int DEFAULT_MODE = 0;
    localparam int RST_PULSE    = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int STAGGER      = 2;
    localparam int MAX_RETRY    = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_REL   = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAIL  = 4;

    logic                clkin = 1'b0;
    logic                reset;
    logic [1:0]          lock;
    logic [1:0]          lock_req;
    logic [1:0]          pll_reset;
    logic [1:0]          domain_rst;
    logic                mode_valid;
    logic [MODE_W-1:0]   mode_sel;
    logic                mode_ready;
    logic [MODE_W-1:0]   cur_mode;
    logic                mode_err;
    logic                all_locked;
    logic                fail;
    logic [3:0]          retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clkin = ~clkin;

    assign lock = lock_req & ~pll_reset;

    tmds_pll_supervisor #(
        .NUM_PLL     (NUM_PLL),
        .NUM_MODES   (NUM_MODES),
        .DEFAULT_MODE(DEFAULT_MODE),
        .RST_PULSE   (RST_PULSE),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STAGGER     (STAGGER),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock      (lock),
        .pll_reset (pll_reset),
        .domain_rst(domain_rst),
        .mode_valid(mode_valid),
        .mode_sel  (mode_sel),
        .mode_ready(mode_ready),
        .cur_mode  (cur_mode),
        .mode_err  (mode_err),
        .all_locked(all_locked),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_ph;
    int         m_t;
    int         m_run;
    int         m_retries;
    int         m_mode;
    bit         m_err;
    bit         m_valid = 1'b0;
    logic [1:0] m_s1, m_s2;

    task automatic enter(input int ph);
        m_ph  = ph;
        m_t   = 0;
        m_run = 0;
    endtask

    task automatic model_step();
        bit up;
        bit req;
        if (reset) begin
            enter(PH_PULSE);
            m_retries = 0;
            m_mode    = DEFAULT_MODE;
            m_err     = 1'b0;
            m_s1      = 2'b00;
            m_s2      = 2'b00;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            up    = (m_s2 == 2'b11);
            req   = (m_ph == PH_RUN || m_ph == PH_FAIL) && mode_valid;
            m_err = 1'b0;
            case (m_ph)
                PH_PULSE: begin
                    if (m_t + 1 == RST_PULSE) enter(PH_WAIT);
                    else m_t++;
                end
                PH_WAIT: begin
                    m_run = up ? m_run + 1 : 0;
                    m_t++;
                    if (m_run == LOCK_STABLE) begin
                        enter(PH_REL);
                    end else if (m_t == LOCK_TIMEOUT) begin
                        m_retries = (m_retries + 1 > 15) ? 15 : m_retries + 1;
                        enter((m_retries < MAX_RETRY) ? PH_PULSE : PH_FAIL);
                    end
                end
                PH_REL: begin
                    if (!up) enter(PH_PULSE);
                    else if (m_t == STAGGER * (NUM_PLL - 1)) begin
                        m_retries = 0;
                        enter(PH_RUN);
                    end else m_t++;
                end
                default: begin
                    if (req && int'(mode_sel) < NUM_MODES) begin
                        m_mode    = int'(mode_sel);
                        m_retries = 0;
                        enter(PH_PULSE);
                    end else begin
                        if (req) m_err = 1'b1;
                        if (m_ph == PH_RUN && !up) enter(PH_PULSE);
                    end
                end
            endcase
            m_s2 = m_s1;
            m_s1 = lock;
        end
    endtask

    initial begin
        forever begin
            @(posedge clkin);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [1:0] e_pr, e_dr;
        forever begin
            @(negedge clkin);
            if (m_valid) begin
                e_pr = (m_ph == PH_PULSE || m_ph == PH_FAIL) ? 2'b11 : 2'b00;
                if (m_ph == PH_RUN) e_dr = 2'b00;
                else if (m_ph == PH_REL) begin
                    for (int i = 0; i < NUM_PLL; i++) e_dr[i] = (m_t < STAGGER * i);
                end else e_dr = 2'b11;
                check("mdl_pll_reset",  32'(pll_reset),  32'(e_pr));
                check("mdl_domain_rst", 32'(domain_rst), 32'(e_dr));
                check("mdl_mode_ready", 32'(mode_ready), 32'(m_ph == PH_RUN || m_ph == PH_FAIL));
                check("mdl_cur_mode",   32'(cur_mode),   32'(m_mode));
                check("mdl_mode_err",   32'(mode_err),   32'(m_err));
                check("mdl_all_locked", 32'(all_locked), 32'(m_ph == PH_RUN));
                check("mdl_fail",       32'(fail),       32'(m_ph == PH_FAIL));
                check("mdl_retry_cnt",  32'(retry_cnt),  32'(m_retries));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clkin);
        reset = 1'b0;
    endtask

    task automatic wait_pll_low(input string name);
        int n = 0;
        while (pll_reset[0] && n < 40) begin
            n++;
            @(negedge clkin);
        end
        check(name, 32'(pll_reset), 32'(2'b00));
    endtask

    task automatic wait_locked(input string name);
        int n = 0;
        while (!all_locked && n < 200) begin
            n++;
            @(negedge clkin);
        end
        check(name, 32'(all_locked), 32'd1);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        lock_req   = 2'b11;
        mode_valid = 1'b0;
        mode_sel   = '0;

        // 1: bring-up with lock requested throughout
        @(negedge clkin);
        check("rst_pll_reset",  32'(pll_reset),  32'(2'b11));
        check("rst_domain_rst", 32'(domain_rst), 32'(2'b11));
        check("rst_mode_ready", 32'(mode_ready), 32'd0);
        repeat (2) @(negedge clkin);
        reset = 1'b0;
        n = 0;
        while (pll_reset[0] && n < 40) begin n++; @(negedge clkin); end
        check("bringup_pll_reset_len", 32'(n), 32'd4);
        n = 0;
        while (domain_rst[0] && n < 100) begin n++; @(negedge clkin); end
        check("bringup_dom0_delay", 32'(n), 32'd10);
        n = 0;
        while (domain_rst[1] && n < 100) begin n++; @(negedge clkin); end
        check("bringup_dom1_stagger", 32'(n), 32'd2);
        n = 0;
        while (!all_locked && n < 100) begin n++; @(negedge clkin); end
        check("bringup_run_delay", 32'(n), 32'd1);
        check("bringup_retry", 32'(retry_cnt), 32'd0);

        // 2: one-cycle glitch on lock[1] after 5 stable cycles
        do_reset();
        wait_pll_low("glitch_wait_entry");
        n = 0;
        while (domain_rst[0] && n < 100) begin
            lock_req = (n == 5) ? 2'b01 : 2'b11;
            n++;
            @(negedge clkin);
        end
        lock_req = 2'b11;
        check("glitch_dom0_delay", 32'(n), 32'd16);
        check("glitch_retry", 32'(retry_cnt), 32'd0);
        wait_locked("glitch_relock");

        // 5: mode switch from RUN
        check("mode_ready_run", 32'(mode_ready), 32'd1);
        mode_valid = 1'b1;
        mode_sel   = 3'd2;
        @(negedge clkin);
        mode_valid = 1'b0;
        check("modesw_cur_mode", 32'(cur_mode), 32'd2);
        check("modesw_all_locked", 32'(all_locked), 32'd0);
        n = 0;
        while (pll_reset[0] && n < 40) begin n++; @(negedge clkin); end
        check("modesw_pll_reset_len", 32'(n), 32'd4);
        wait_locked("modesw_relock");

        // 6: out-of-range mode request
        mode_valid = 1'b1;
        mode_sel   = 3'd5;
        @(negedge clkin);
        mode_valid = 1'b0;
        check("badmode_err", 32'(mode_err), 32'd1);
        check("badmode_cur_mode", 32'(cur_mode), 32'd2);
        check("badmode_locked", 32'(all_locked), 32'd1);
        @(negedge clkin);
        check("badmode_err_pulse", 32'(mode_err), 32'd0);

        // 4: one-cycle loss of lock[0] in RUN
        lock_req = 2'b10;
        @(negedge clkin);
        lock_req = 2'b11;
        check("loss_dom_d1", 32'(domain_rst), 32'(2'b00));
        @(negedge clkin);
        check("loss_dom_d2", 32'(domain_rst), 32'(2'b00));
        @(negedge clkin);
        check("loss_dom_d3", 32'(domain_rst), 32'(2'b11));
        check("loss_locked_d3", 32'(all_locked), 32'd0);

        // reset in the middle of RELEASE
        n = 0;
        while (domain_rst !== 2'b10 && n < 100) begin n++; @(negedge clkin); end
        check("midrel_reached", 32'(domain_rst), 32'(2'b10));
        reset    = 1'b1;
        lock_req = 2'b01;
        @(negedge clkin);
        check("midrel_pll_reset", 32'(pll_reset), 32'(2'b11));
        check("midrel_domain_rst", 32'(domain_rst), 32'(2'b11));
        check("midrel_cur_mode", 32'(cur_mode), 32'd0);
        check("midrel_mode_ready", 32'(mode_ready), 32'd0);
        check("midrel_retry", 32'(retry_cnt), 32'd0);
        reset = 1'b0;

        // 3: lock[1] never comes up
        wait_pll_low("tmo_wait_entry1");
        n = 0;
        while (retry_cnt == 4'd0 && n < 200) begin n++; @(negedge clkin); end
        check("tmo_first_len", 32'(n), 32'd64);
        check("tmo_first_retry", 32'(retry_cnt), 32'd1);
        check("tmo_first_pll_reset", 32'(pll_reset), 32'(2'b11));
        n = 0;
        while (pll_reset[0] && n < 40) begin n++; @(negedge clkin); end
        check("tmo_repulse_len", 32'(n), 32'd4);
        n = 0;
        while (!fail && n < 200) begin n++; @(negedge clkin); end
        check("tmo_second_len", 32'(n), 32'd64);
        check("tmo_fail_retry", 32'(retry_cnt), 32'd2);
        check("tmo_fail_pll_reset", 32'(pll_reset), 32'(2'b11));
        check("tmo_fail_ready", 32'(mode_ready), 32'd1);
        repeat (5) @(negedge clkin);
        check("tmo_fail_sticky", 32'(fail), 32'd1);

        // 5b: mode request recovers from FAIL
        lock_req   = 2'b11;
        mode_valid = 1'b1;
        mode_sel   = 3'd2;
        @(negedge clkin);
        mode_valid = 1'b0;
        check("recover_fail_low", 32'(fail), 32'd0);
        check("recover_cur_mode", 32'(cur_mode), 32'd2);
        check("recover_retry", 32'(retry_cnt), 32'd0);
        wait_locked("recover_relock");
        repeat (3) @(negedge clkin);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
